ldpc_batch_ctrl: RTL and testbench

- Synthesizable, parametrised batch controller for the one-step majority-logic LDPC decoder.
- Holds a bank of received frames and their golden codewords, and issues frames to the decoder over the work/free/valid handshake.
- Captures the decoded words, compares each against its golden word, and accumulates pass, bit-error and timeout statistics.
- Used for on-chip BER/FER measurement without an external bench.

---
 rtl/ldpc_batch_ctrl.sv | 174 +++++++++++++++++
 tb/tb_ldpc_batch_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ldpc_batch_ctrl.sv
// Batch controller for the majority-logic LDPC decoder: streams stored frames to the
// decoder, captures decoded words, and accumulates pass / bit-error / timeout statistics.
module ldpc_batch_ctrl #(
  parameter int N_BITS   = 256,
  parameter int N_FRAMES = 100,
  parameter int AW       = 7,
  parameter int ERR_W    = 16,
  parameter int TIMEOUT  = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              wr_sel,
  input  logic [AW-1:0]     wr_addr,
  input  logic [N_BITS-1:0] wr_data,
  input  logic              start,
  input  logic [AW:0]       run_len,
  input  logic [AW-1:0]     rd_addr,
  output logic [N_BITS-1:0] rd_data,
  output logic [N_BITS-1:0] dec_tx,
  output logic              dec_work,
  input  logic              dec_free,
  input  logic [N_BITS-1:0] dec_deout,
  input  logic              dec_valid,
  output logic              busy,
  output logic              done,
  output logic [AW:0]       pass_cnt,
  output logic [ERR_W-1:0]  bit_err_cnt,
  output logic [AW:0]       timeout_cnt
);

  localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam int PW = $clog2(N_BITS + 1);
  localparam logic [AW:0]   NF   = (AW+1)'(N_FRAMES);
  localparam logic [AW:0]   ONE  = (AW+1)'(1);
  localparam logic [TW-1:0] TMO  = TW'(TIMEOUT);
  localparam logic [TW-1:0] TONE = TW'(1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  function automatic logic [PW-1:0] popcount(input logic [N_BITS-1:0] v);
    logic [PW-1:0] c;
    c = '0;
    for (int i = 0; i < N_BITS; i++) c = c + PW'(v[i]);
    return c;
  endfunction

  function automatic logic [ERR_W-1:0] sat_add(input logic [ERR_W-1:0] a,
                                               input logic [PW-1:0] b);
    logic [ERR_W:0] s;
    s = {1'b0, a} + (ERR_W+1)'(b);
    return s[ERR_W] ? {ERR_W{1'b1}} : s[ERR_W-1:0];
  endfunction

  logic [N_BITS-1:0] in_mem   [N_FRAMES];
  logic [N_BITS-1:0] gold_mem [N_FRAMES];
  logic [N_BITS-1:0] out_mem  [N_FRAMES];

  logic [2:0]        state;
  logic [AW-1:0]     idx;
  logic [AW:0]       run_q;
  logic [TW-1:0]     wcnt;
  logic [N_BITS-1:0] cap_p1;
  logic [N_BITS-1:0] gold_p1;
  logic [PW-1:0]     err_p1;
  logic [AW:0]       run_clamp;
  logic              idle_like;
  logic              last;
  logic              tmo_hit;
  logic              adv;
  logic              cap_en;
  logic              wr_ok;
  logic              rd_ok;

  assign idle_like = (state == S_IDLE) || (state == S_DONE);
  assign run_clamp = (run_len > NF) ? NF : run_len;
  assign last      = ({1'b0, idx} + ONE) == run_q;
  assign cap_en    = (state == S_WAIT) && dec_valid;
  // A valid arriving on the terminal count still wins over the timeout.
  assign tmo_hit   = (state == S_WAIT) && !dec_valid && (wcnt == TMO);
  assign adv       = tmo_hit || (state == S_CHECK);
  assign err_p1    = popcount(cap_p1 ^ gold_p1);
  assign wr_ok     = wr_en && idle_like && ({1'b0, wr_addr} < NF);
  assign rd_ok     = {1'b0, rd_addr} < NF;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      idx         <= '0;
      run_q       <= '0;
      wcnt        <= '0;
      dec_work    <= 1'b0;
      dec_tx      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass_cnt    <= '0;
      bit_err_cnt <= '0;
      timeout_cnt <= '0;
    end else begin
      dec_work <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            pass_cnt    <= '0;
            bit_err_cnt <= '0;
            timeout_cnt <= '0;
            idx         <= '0;
            run_q       <= run_clamp;
            if (run_clamp == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state <= S_ISSUE;
              done  <= 1'b0;
              busy  <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          dec_tx <= in_mem[idx];
          if (dec_free) begin
            dec_work <= 1'b1;
            wcnt     <= '0;
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (dec_valid) state <= S_CHECK;
          else if (tmo_hit) timeout_cnt <= timeout_cnt + ONE;
          else wcnt <= wcnt + TONE;
        end
        S_CHECK: begin
          if (err_p1 == '0) pass_cnt <= pass_cnt + ONE;
          bit_err_cnt <= sat_add(bit_err_cnt, err_p1);
        end
        default: state <= S_IDLE;
      endcase
      if (adv) begin
        if (last) begin
          state <= S_DONE;
          done  <= 1'b1;
          busy  <= 1'b0;
        end else begin
          idx   <= idx + 1'b1;
          state <= S_ISSUE;
        end
      end
    end
  end

  // capture stage: decoded word and its golden reference, consumed by CHECK
  always_ff @(posedge clk) begin
    if (cap_en) begin
      cap_p1       <= dec_deout;
      gold_p1      <= gold_mem[idx];
      out_mem[idx] <= dec_deout;
    end
    if (wr_ok) begin
      if (wr_sel) gold_mem[wr_addr] <= wr_data;
      else        in_mem[wr_addr]   <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_data <= '0;
    else     rd_data <= rd_ok ? out_mem[rd_addr] : '0;
  end

endmodule

// File: tb/tb_ldpc_batch_ctrl.sv
// Bench for ldpc_batch_ctrl: random frames, a behavioural decoder, and a frame-level
// reference model of the expected batch statistics.
`timescale 1ns/1ps
module tb_ldpc_batch_ctrl;
  localparam int N_BITS   = 256;
  localparam int N_FRAMES = 100;
  localparam int AW       = 7;
  localparam int ERR_W    = 10;
  localparam int TIMEOUT  = 15;
  localparam int ERR_MAX  = (1 << ERR_W) - 1;

  logic              clk_tb = 1'b0;
  logic              rst, wr_en, wr_sel, start, dec_free, dec_valid;
  logic [AW-1:0]     wr_addr, rd_addr;
  logic [N_BITS-1:0] wr_data, rd_data, dec_tx, dec_deout;
  logic [AW:0]       run_len, pass_cnt, timeout_cnt;
  logic [ERR_W-1:0]  bit_err_cnt;
  logic              dec_work, busy, done;

  ldpc_batch_ctrl #(.N_BITS(N_BITS), .N_FRAMES(N_FRAMES), .AW(AW),
                    .ERR_W(ERR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk_tb), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .start(start), .run_len(run_len), .rd_addr(rd_addr),
    .rd_data(rd_data), .dec_tx(dec_tx), .dec_work(dec_work), .dec_free(dec_free),
    .dec_deout(dec_deout), .dec_valid(dec_valid), .busy(busy), .done(done),
    .pass_cnt(pass_cnt), .bit_err_cnt(bit_err_cnt), .timeout_cnt(timeout_cnt));

  always #5 clk_tb = ~clk_tb;

  int errors = 0;
  int checks = 0;

  // behavioural decoder controls
  logic              drop_en   = 1'b0;
  logic [N_BITS-1:0] drop_word = '0;
  int                lat_force = 0;
  logic              spur_req  = 1'b0;

  // reference model state
  logic [N_BITS-1:0] in_m  [N_FRAMES];
  logic [N_BITS-1:0] gold_m[N_FRAMES];
  logic [N_BITS-1:0] out_e [N_FRAMES];

  // dec_work monitor
  int   cyc = 0;
  int   work_cnt = 0;
  int   wide_cnt = 0;
  int   work_cyc [1024];
  logic prev_work = 1'b0;

  function automatic logic [N_BITS-1:0] rand_word();
    logic [N_BITS-1:0] w;
    for (int i = 0; i < N_BITS / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  function automatic logic [N_BITS-1:0] dec_fn(input logic [N_BITS-1:0] x);
    logic [N_BITS-1:0] key;
    key = {8{32'h5A3C_96E1}};
    return x ^ key;
  endfunction

  task automatic chk(input string tag, input logic [N_BITS-1:0] obs,
                     input logic [N_BITS-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk_tb) cyc <= cyc + 1;

  initial begin
    forever begin
      @(negedge clk_tb);
      if (dec_work === 1'b1) begin
        if (prev_work) wide_cnt++;
        if (work_cnt < 1024) work_cyc[work_cnt] = cyc;
        work_cnt++;
      end
      prev_work = dec_work;
    end
  end

  initial begin
    logic [N_BITS-1:0] tx;
    int lat;
    dec_valid = 1'b0;
    dec_deout = '0;
    forever begin
      @(negedge clk_tb);
      if (dec_work === 1'b1) begin
        tx = dec_tx;
        dec_valid = 1'b0;
        if (!(drop_en && tx == drop_word)) begin
          lat = (lat_force != 0) ? lat_force : int'($urandom_range(0, 3));
          repeat (lat) @(negedge clk_tb);
          dec_deout = dec_fn(tx);
          dec_valid = 1'b1;
          @(negedge clk_tb);
          dec_valid = 1'b0;
          dec_deout = rand_word();
        end
      end else begin
        dec_valid = spur_req;
        dec_deout = rand_word();
      end
    end
  end

  task automatic model_batch(input int req, output int e_pass, output int e_err,
                             output int e_tmo);
    int n;
    n = (req > N_FRAMES) ? N_FRAMES : req;
    e_pass = 0; e_err = 0; e_tmo = 0;
    for (int i = 0; i < n; i++) begin
      if (drop_en && in_m[i] == drop_word) e_tmo++;
      else begin
        logic [N_BITS-1:0] d;
        int e;
        d = dec_fn(in_m[i]);
        e = $countones(d ^ gold_m[i]);
        out_e[i] = d;
        if (e == 0) e_pass++;
        e_err = (e_err + e > ERR_MAX) ? ERR_MAX : e_err + e;
      end
    end
  endtask

  task automatic load(input logic sel, input int addr, input logic [N_BITS-1:0] d);
    wr_en = 1'b1; wr_sel = sel; wr_addr = addr[AW-1:0]; wr_data = d;
    @(negedge clk_tb);
    wr_en = 1'b0;
  endtask

  task automatic load_frame(input int i);
    load(1'b0, i, in_m[i]);
    load(1'b1, i, gold_m[i]);
  endtask

  task automatic wait_done(input string tag);
    int b;
    b = 0;
    while (done !== 1'b1 && b < 5000) begin @(negedge clk_tb); b++; end
    chk({tag, " done"}, N_BITS'(done), N_BITS'(1));
  endtask

  task automatic run_batch(input int len, input string tag);
    int ep, ee, et;
    model_batch(len, ep, ee, et);
    run_len = len[AW:0];
    start = 1'b1;
    @(negedge clk_tb);
    start = 1'b0;
    wait_done(tag);
    chk({tag, " busy"}, N_BITS'(busy), '0);
    chk({tag, " pass_cnt"}, N_BITS'(pass_cnt), N_BITS'(ep));
    chk({tag, " bit_err_cnt"}, N_BITS'(bit_err_cnt), N_BITS'(ee));
    chk({tag, " timeout_cnt"}, N_BITS'(timeout_cnt), N_BITS'(et));
  endtask

  task automatic chk_rd(input int a, input logic [N_BITS-1:0] exp, input string tag);
    rd_addr = a[AW-1:0];
    @(negedge clk_tb);
    chk(tag, rd_data, exp);
  endtask

  initial begin
    int w0, b, ep, ee, et;
    logic [N_BITS-1:0] flip, one_hot;
    rst = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; run_len = '0; rd_addr = '0; dec_free = 1'b1;
    repeat (3) @(negedge clk_tb);
    chk("rst busy", N_BITS'(busy), '0);
    chk("rst done", N_BITS'(done), '0);
    chk("rst dec_work", N_BITS'(dec_work), '0);
    chk("rst pass_cnt", N_BITS'(pass_cnt), '0);
    chk("rst bit_err_cnt", N_BITS'(bit_err_cnt), '0);
    chk("rst timeout_cnt", N_BITS'(timeout_cnt), '0);
    chk("rst dec_tx", dec_tx, '0);
    chk("rst rd_data", rd_data, '0);
    rst = 1'b0;
    @(negedge clk_tb);

    // all four frames decode to their golden words
    for (int i = 0; i < 4; i++) begin
      in_m[i] = rand_word();
      gold_m[i] = dec_fn(in_m[i]);
      load_frame(i);
    end
    w0 = work_cnt;
    run_batch(4, "t1");
    chk("t1 work pulses", N_BITS'(work_cnt - w0), N_BITS'(4));
    chk("t1 work width", N_BITS'(wide_cnt), '0);

    // three flipped bits in frame 2's golden word
    flip = '0; flip[0] = 1'b1; flip[100] = 1'b1; flip[255] = 1'b1;
    gold_m[2] = dec_fn(in_m[2]) ^ flip;
    load(1'b1, 2, gold_m[2]);
    run_batch(4, "t2");
    chk("t2 pass_cnt abs", N_BITS'(pass_cnt), N_BITS'(3));
    chk("t2 bit_err_cnt abs", N_BITS'(bit_err_cnt), N_BITS'(3));
    chk_rd(2, dec_fn(in_m[2]), "t2 rd_data[2]");

    // decoder never answers frame 1
    gold_m[2] = dec_fn(in_m[2]);
    load(1'b1, 2, gold_m[2]);
    drop_en = 1'b1; drop_word = in_m[1];
    w0 = work_cnt;
    run_batch(3, "t3");
    drop_en = 1'b0;
    chk("t3 timeout abs", N_BITS'(timeout_cnt), N_BITS'(1));
    chk("t3 issue gap", N_BITS'(work_cyc[w0+2] - work_cyc[w0+1]), N_BITS'(TIMEOUT + 2));
    chk_rd(1, out_e[1], "t3 rd_data[1] kept");

    // decoder busy for 50 cycles; stray valids and a write while busy must be ignored
    dec_free = 1'b0; spur_req = 1'b1;
    w0 = work_cnt;
    model_batch(1, ep, ee, et);
    run_len = 1; start = 1'b1;
    @(negedge clk_tb);
    start = 1'b0;
    load(1'b0, 0, ~in_m[0]);
    repeat (49) @(negedge clk_tb);
    chk("t4 no work", N_BITS'(work_cnt - w0), '0);
    chk("t4 no timeout", N_BITS'(timeout_cnt), '0);
    chk("t4 busy", N_BITS'(busy), N_BITS'(1));
    spur_req = 1'b0;
    @(negedge clk_tb);
    dec_free = 1'b1;
    @(negedge clk_tb);
    chk("t4 first-cycle issue", N_BITS'(dec_work), N_BITS'(1));
    wait_done("t4");
    chk("t4 pass_cnt", N_BITS'(pass_cnt), N_BITS'(ep));
    chk("t4 bit_err_cnt", N_BITS'(bit_err_cnt), N_BITS'(ee));

    // zero-length batch
    w0 = work_cnt;
    run_len = 0; start = 1'b1;
    @(negedge clk_tb);
    start = 1'b0;
    @(negedge clk_tb);
    chk("t5 zero done", N_BITS'(done), N_BITS'(1));
    chk("t5 zero busy", N_BITS'(busy), '0);
    chk("t5 zero pass", N_BITS'(pass_cnt), '0);
    chk("t5 zero err", N_BITS'(bit_err_cnt), '0);
    chk("t5 zero tmo", N_BITS'(timeout_cnt), '0);
    chk("t5 zero work", N_BITS'(work_cnt - w0), '0);

    // oversized batch: clamped to every slot, error count saturates
    for (int i = 0; i < N_FRAMES; i++) begin
      in_m[i] = rand_word();
      one_hot = '0; one_hot[i] = 1'b1;
      case (i % 3)
        0:       gold_m[i] = rand_word();
        1:       gold_m[i] = dec_fn(in_m[i]) ^ one_hot;
        default: gold_m[i] = dec_fn(in_m[i]);
      endcase
      load_frame(i);
    end
    w0 = work_cnt;
    run_batch(200, "t5big");
    chk("t5big work pulses", N_BITS'(work_cnt - w0), N_BITS'(N_FRAMES));
    chk("t5big err saturated", N_BITS'(bit_err_cnt), N_BITS'(ERR_MAX));
    for (int k = 0; k < 4; k++) begin
      b = $urandom_range(0, N_FRAMES - 1);
      chk_rd(b, out_e[b], "t5big rd_data");
    end
    chk_rd(120, '0, "rd out of range");

    // reset in the middle of frame 5's wait
    lat_force = 8;
    w0 = work_cnt;
    run_len = 10; start = 1'b1;
    @(negedge clk_tb);
    start = 1'b0;
    b = 0;
    while (work_cnt < w0 + 6 && b < 2000) begin @(negedge clk_tb); b++; end
    chk("t6 reached frame 5", N_BITS'(work_cnt - w0), N_BITS'(6));
    rst = 1'b1;
    #1;
    chk("t6 rst busy", N_BITS'(busy), '0);
    chk("t6 rst done", N_BITS'(done), '0);
    chk("t6 rst work", N_BITS'(dec_work), '0);
    chk("t6 rst pass", N_BITS'(pass_cnt), '0);
    chk("t6 rst err", N_BITS'(bit_err_cnt), '0);
    chk("t6 rst tmo", N_BITS'(timeout_cnt), '0);
    @(negedge clk_tb);
    rst = 1'b0;
    lat_force = 0;
    repeat (20) @(negedge clk_tb);
    run_batch(2, "t6after");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
